// File: rtl/wgt_pkg.sv
// Shared constants and width helpers for weight/threshold blocks.
// Field widths are derived here so every user sizes weights the same way.
package wgt_pkg;

    localparam int PIPE_LAT = 3;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 16; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return (res < 1) ? 1 : res;
    endfunction

    // A popcount of an n-bit vector needs to hold values 0..n.
    function automatic int wgt_width(input int width);
        return clog2(width + 1);
    endfunction

    localparam int WW = wgt_width(12);

endpackage

// File: rtl/popcnt.sv
// Combinational population count of an N-bit vector.
module popcnt
    import wgt_pkg::*;
#(
    parameter  int N  = 6,
    localparam int OW = wgt_width(N)
) (
    input  logic [N-1:0]  v,
    output logic [OW-1:0] cnt
);

    // Ripple-add each bit into the running count.
    always_comb begin
        cnt = {OW{1'b0}};
        for (int i = 0; i < N; i++) begin
            cnt = cnt + OW'(v[i]);
        end
    end

endmodule

// File: rtl/wgt_thresh.sv
// Three-stage Hamming-weight threshold checker with a saturating failure counter.
// THR rides alongside its own sample so threshold changes never disturb in-flight data.
module wgt_thresh
    import wgt_pkg::*;
#(
    parameter  int WIDTH = 12,
    parameter  int CNT_W = 16,
    localparam int WW    = wgt_width(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             VLD,
    input  logic [WIDTH-1:0] V,
    input  logic [WW-1:0]    THR,
    input  logic             CLR,
    output logic             OVLD,
    output logic [WW-1:0]    WGT,
    output logic             WLTEQ,
    output logic             WEQ,
    output logic [CNT_W-1:0] FAIL_CNT
);

    localparam int LO_N = (WIDTH + 1) / 2;
    localparam int HI_N = WIDTH / 2;
    localparam int LO_W = wgt_width(LO_N);
    localparam int HI_W = wgt_width(HI_N);

    logic [WIDTH-1:0] v_r;
    logic [WW-1:0]    thr1_r;
    logic             vld1_r;
    logic [LO_W-1:0]  lo_cnt_s;
    logic [HI_W-1:0]  hi_cnt_s;
    logic [LO_W-1:0]  lo_cnt_r;
    logic [HI_W-1:0]  hi_cnt_r;
    logic [WW-1:0]    thr2_r;
    logic             vld2_r;
    logic [WW-1:0]    sum_s;
    logic             lteq_s;
    logic             eq_s;
    logic             fail_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Stage 1: capture the raw sample.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v_r    <= {WIDTH{1'b0}};
            thr1_r <= {WW{1'b0}};
            vld1_r <= 1'b0;
        end else begin
            v_r    <= V;
            thr1_r <= THR;
            vld1_r <= VLD;
        end
    end

    popcnt #(.N(LO_N)) u_pop_lo (
        .v   (v_r[LO_N-1:0]),
        .cnt (lo_cnt_s)
    );

    popcnt #(.N(HI_N)) u_pop_hi (
        .v   (v_r[WIDTH-1:LO_N]),
        .cnt (hi_cnt_s)
    );

    // Stage 2: half-vector partial counts.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lo_cnt_r <= {LO_W{1'b0}};
            hi_cnt_r <= {HI_W{1'b0}};
            thr2_r   <= {WW{1'b0}};
            vld2_r   <= 1'b0;
        end else begin
            lo_cnt_r <= lo_cnt_s;
            hi_cnt_r <= hi_cnt_s;
            thr2_r   <= thr1_r;
            vld2_r   <= vld1_r;
        end
    end

    // Final weight and comparisons; both operands are unsigned.
    always_comb begin
        sum_s  = WW'(lo_cnt_r) + WW'(hi_cnt_r);
        lteq_s = (sum_s <= thr2_r);
        eq_s   = (sum_s == thr2_r);
        fail_s = vld2_r & ~lteq_s;
    end

    // Stage 3: results update only on valid samples and hold otherwise.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OVLD  <= 1'b0;
            WGT   <= {WW{1'b0}};
            WLTEQ <= 1'b0;
            WEQ   <= 1'b0;
        end else begin
            OVLD <= vld2_r;
            if (vld2_r) begin
                WGT   <= sum_s;
                WLTEQ <= lteq_s;
                WEQ   <= eq_s;
            end else begin
                WGT   <= WGT;
                WLTEQ <= WLTEQ;
                WEQ   <= WEQ;
            end
        end
    end

    // Failure count next state: clear dominates, then saturating increment.
    always_comb begin
        cnt_nxt_s = FAIL_CNT;
        if (CLR) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (fail_s && (FAIL_CNT != {CNT_W{1'b1}})) begin
            cnt_nxt_s = FAIL_CNT + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = FAIL_CNT;
        end
    end

    // Failure counter register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            FAIL_CNT <= {CNT_W{1'b0}};
        end else begin
            FAIL_CNT <= cnt_nxt_s;
        end
    end

endmodule

// File: doc/wgt_thresh.md
WGT_THRESH -- requirements
Module: wgt_thresh

Interface
REQ-001 Parameter WIDTH, default 12, is the input vector width; legal range 2..64.
REQ-002 Parameter CNT_W, default 16, is the width of the failure counter.
REQ-003 Derived constant WW = clog2(WIDTH+1) is the width of the weight and threshold fields.
REQ-004 Port CLK, input, 1, is the single clock; all state is updated on its rising edge.
REQ-005 Port RST_N, input, 1, is the asynchronous active-low reset.
REQ-006 Port VLD, input, 1, qualifies V and THR in the current cycle.
REQ-007 Port V, input, WIDTH, is the vector whose Hamming weight is evaluated.
REQ-008 Port THR, input, WW, is the runtime weight threshold, sampled together with V.
REQ-009 Port CLR, input, 1, is a synchronous clear of FAIL_CNT.
REQ-010 Port OVLD, output, 1, marks valid result outputs.
REQ-011 Port WGT, output, WW, is the popcount of V.
REQ-012 Port WLTEQ, output, 1, is 1 when WGT <= THR.
REQ-013 Port WEQ, output, 1, is 1 when WGT == THR.
REQ-014 Port FAIL_CNT, output, CNT_W, counts valid samples with WGT > THR.

Function
REQ-015 The block shall be a 3-stage pipeline with a fixed latency of 3 cycles from the VLD/V/THR sample to OVLD/WGT/WLTEQ/WEQ.
REQ-016 Stage 1 shall register V, THR and VLD.
REQ-017 Stage 2 shall register the popcounts of the lower ceil(WIDTH/2) bits and the upper floor(WIDTH/2) bits, together with THR and VLD.
REQ-018 Stage 3 shall register the sum of the two partial popcounts as WGT, the comparison results, and OVLD.
REQ-019 The pipeline shall accept a new sample every cycle with no stalls or bubbles; back-to-back samples shall produce back-to-back results.
REQ-020 THR shall travel through the pipeline with its own sample, so that changing THR between samples never affects an in-flight result.
REQ-021 WGT shall be unsigned; a THR value above WIDTH is legal and shall yield WLTEQ=1 and WEQ=0.
REQ-022 When OVLD=0, WGT, WLTEQ and WEQ shall hold their last valid values.
REQ-023 FAIL_CNT shall increment by 1 in the cycle in which the stage-3 result is registered with OVLD=1 and WLTEQ=0.
REQ-024 FAIL_CNT shall saturate at all-ones and shall not wrap.
REQ-025 CLR shall set FAIL_CNT to 0 on the next edge; when CLR coincides with an increment, CLR wins and the count becomes 0.
REQ-026 CLR shall not affect the pipeline data path.

Reset
REQ-027 Asserting RST_N low shall asynchronously clear all pipeline valid bits, OVLD, WGT, WLTEQ, WEQ and FAIL_CNT to 0.
REQ-028 Samples in flight at reset shall be discarded and shall produce no OVLD after reset is released.
REQ-029 The first OVLD after release shall appear 3 cycles after the first VLD sampled with RST_N high.

Structure
REQ-030 WW, the clog2 function and the pipeline-latency constant (3) shall reside in the shared package wgt_pkg, used by the ECC blocks.
REQ-031 Popcount shall be a combinational sub-module popcnt, parameterised by input width and instantiated twice, once per half-vector in stage 2.

Verification
REQ-032 WIDTH=12, THR=3: V=12'h007, then 12'h00F, then 12'hE00 on consecutive cycles -> OVLD high on cycles 3..5; WGT=3/4/3; WLTEQ=1/0/1; WEQ=1/0/1; FAIL_CNT=1 after the second result.
REQ-033 WIDTH=12, THR=3: all 4096 values of V streamed back-to-back -> WLTEQ equals (popcount(V)<=3) for every sample; FAIL_CNT=3797 at the end.
REQ-034 THR toggled 0,12,13 per sample with V=12'hFFF -> WLTEQ=0/1/1; WEQ=0/1/0.
REQ-035 CNT_W=4: 20 failing samples -> FAIL_CNT stops at 15; CLR asserted in the same cycle as a failure -> FAIL_CNT=0.
REQ-036 RST_N pulsed low while 2 samples are in flight -> all outputs are 0 immediately; no OVLD follows; the next sample gives OVLD after 3 cycles.
REQ-037 WIDTH=5 and WIDTH=64: random V and THR -> WGT equals popcount(V) at latency 3.
